// File: rtl/stream_param_1to2_demux_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream, two output
// streams and the per-output delivery counters.
interface stream_param_1to2_demux_if #(
  parameter int unsigned nbits = 8
);
  logic             in_val;
  logic             in_rdy;
  logic [nbits-1:0] in_msg;
  logic             in_sel;

  logic             out0_val;
  logic             out0_rdy;
  logic [nbits-1:0] out0_msg;

  logic             out1_val;
  logic             out1_rdy;
  logic [nbits-1:0] out1_msg;

  logic [7:0]       count0;
  logic [7:0]       count1;

  // Environment side: produces the input stream, consumes both outputs.
  modport master (
    output in_val, in_msg, in_sel, out0_rdy, out1_rdy,
    input  in_rdy, out0_val, out0_msg, out1_val, out1_msg, count0, count1
  );

  // Demux side.
  modport slave (
    input  in_val, in_msg, in_sel, out0_rdy, out1_rdy,
    output in_rdy, out0_val, out0_msg, out1_val, out1_msg, count0, count1
  );
endinterface

// File: rtl/stream_param_1to2_demux.sv
// Single-entry 1-to-2 stream demultiplexer. A message accepted on the input is
// held in a one-deep buffer and presented on the output chosen by its select
// bit one cycle later. Outputs come straight from the buffer registers; the
// only combinational path through the block is selected out_rdy -> in_rdy,
// which lets a draining buffer refill in the same cycle for full throughput.
module stream_param_1to2_demux #(
  parameter int unsigned nbits = 8
) (
  input logic                      clk,
  input logic                      reset,
  stream_param_1to2_demux_if.slave bus
);

  logic             buf_full_q, buf_full_d;
  logic [nbits-1:0] buf_msg_q,  buf_msg_d;
  logic             buf_sel_q,  buf_sel_d;
  logic [7:0]       count0_q,   count0_d;
  logic [7:0]       count1_q,   count1_d;

  logic out0_val, out1_val;
  logic out0_fire, out1_fire, out_fire;
  logic in_rdy, in_fire;

  // Handshake decode: output fires depend only on registered val and the
  // consumer's rdy; in_rdy is forced low while reset is held.
  always_comb begin
    out0_val  = buf_full_q & ~buf_sel_q;
    out1_val  = buf_full_q &  buf_sel_q;
    out0_fire = out0_val & bus.out0_rdy;
    out1_fire = out1_val & bus.out1_rdy;
    out_fire  = out0_fire | out1_fire;
    in_rdy    = reset & (~buf_full_q | out_fire);
    in_fire   = bus.in_val & in_rdy;
  end

  // Buffer and counter next state: a load wins over a drain so a message
  // arriving while the old one leaves simply replaces it.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_msg_d  = buf_msg_q;
    buf_sel_d  = buf_sel_q;
    count0_d   = count0_q;
    count1_d   = count1_q;

    if (in_fire) begin
      buf_full_d = 1'b1;
      buf_msg_d  = bus.in_msg;
      buf_sel_d  = bus.in_sel;
    end else if (out_fire) begin
      buf_full_d = 1'b0;
    end

    // Counters wrap naturally at 8 bits.
    if (out0_fire) begin
      count0_d = count0_q + 8'd1;
    end
    if (out1_fire) begin
      count1_d = count1_q + 8'd1;
    end
  end

  // State registers; asynchronous reset discards any buffered message.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full_q <= 1'b0;
      buf_msg_q  <= '0;
      buf_sel_q  <= 1'b0;
      count0_q   <= 8'd0;
      count1_q   <= 8'd0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_msg_q  <= buf_msg_d;
      buf_sel_q  <= buf_sel_d;
      count0_q   <= count0_d;
      count1_q   <= count1_d;
    end
  end

  // Output drive: message bus reads zero on the output that is not valid.
  always_comb begin
    bus.in_rdy   = in_rdy;
    bus.out0_val = out0_val;
    bus.out1_val = out1_val;
    bus.out0_msg = out0_val ? buf_msg_q : '0;
    bus.out1_msg = out1_val ? buf_msg_q : '0;
    bus.count0   = count0_q;
    bus.count1   = count1_q;
  end

endmodule

// File: tb/tb_stream_param_1to2_demux.sv
// Self-checking bench for stream_param_1to2_demux. A 4-bit instance covers the
// basic single-message case; a 13-bit instance carries a scoreboard that
// records every accepted input per destination and checks each delivery.
module tb_stream_param_1to2_demux;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  stream_param_1to2_demux_if #(.nbits(4))  bus4  ();
  stream_param_1to2_demux_if #(.nbits(13)) bus13 ();

  stream_param_1to2_demux #(.nbits(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  stream_param_1to2_demux #(.nbits(13)) dut13 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus13.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [7:0]  m_cnt0 = 8'd0;
  logic [7:0]  m_cnt1 = 8'd0;
  bit          sb_on  = 1'b0;
  logic [12:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the 13-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_on && reset) begin
      if (bus13.out0_val && bus13.out0_rdy) begin
        if (q0.size() == 0) begin
          check_eq("out0_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = q0.pop_front();
          check_eq("out0_msg", 32'(bus13.out0_msg), 32'(mon_exp));
        end
        m_cnt0 = m_cnt0 + 8'd1;
      end
      if (bus13.out1_val && bus13.out1_rdy) begin
        if (q1.size() == 0) begin
          check_eq("out1_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = q1.pop_front();
          check_eq("out1_msg", 32'(bus13.out1_msg), 32'(mon_exp));
        end
        m_cnt1 = m_cnt1 + 8'd1;
      end
      if (!bus13.out0_val) check_eq("out0_msg_idle", 32'(bus13.out0_msg), 32'd0);
      if (!bus13.out1_val) check_eq("out1_msg_idle", 32'(bus13.out1_msg), 32'd0);
      if (bus13.in_val && bus13.in_rdy) begin
        if (bus13.in_sel) q1.push_back(bus13.in_msg);
        else              q0.push_back(bus13.in_msg);
      end
    end
  end

  // Hard stop if the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  sel_pat;
    int          sent;
    int          guard;
    logic        acc;

    sel_pat = 3'b101;

    bus4.in_val = 1'b0; bus4.in_msg = '0; bus4.in_sel = 1'b0;
    bus4.out0_rdy = 1'b0; bus4.out1_rdy = 1'b0;
    bus13.in_val = 1'b0; bus13.in_msg = '0; bus13.in_sel = 1'b0;
    bus13.out0_rdy = 1'b0; bus13.out1_rdy = 1'b0;

    // Reset state while reset is held.
    #12;
    check_eq("rst_in_rdy",   32'(bus13.in_rdy),   32'd0);
    check_eq("rst_out0_val", 32'(bus13.out0_val), 32'd0);
    check_eq("rst_out1_val", 32'(bus13.out1_val), 32'd0);
    check_eq("rst_count0",   32'(bus13.count0),   32'd0);
    check_eq("rst_count1",   32'(bus13.count1),   32'd0);
    check_eq("rst4_in_rdy",  32'(bus4.in_rdy),    32'd0);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("post_rst_in_rdy",  32'(bus13.in_rdy), 32'd1);
    check_eq("post_rst4_in_rdy", 32'(bus4.in_rdy),  32'd1);

    // nbits=4: single message to out0.
    bus4.in_val = 1'b1; bus4.in_msg = 4'd5; bus4.in_sel = 1'b0; bus4.out0_rdy = 1'b1;
    tick();
    bus4.in_val = 1'b0;
    check_eq("n4_out0_val", 32'(bus4.out0_val), 32'd1);
    check_eq("n4_out0_msg", 32'(bus4.out0_msg), 32'd5);
    check_eq("n4_out1_val", 32'(bus4.out1_val), 32'd0);
    check_eq("n4_out1_msg", 32'(bus4.out1_msg), 32'd0);
    tick();
    check_eq("n4_count0",    32'(bus4.count0),   32'd1);
    check_eq("n4_count1",    32'(bus4.count1),   32'd0);
    check_eq("n4_out0_done", 32'(bus4.out0_val), 32'd0);

    // nbits=13: back-to-back 1,2,3 with sel 1,0,1.
    sb_on = 1'b1;
    bus13.out0_rdy = 1'b1; bus13.out1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus13.in_val = 1'b1; bus13.in_msg = 13'(i + 1); bus13.in_sel = sel_pat[i];
      #1;
      check_eq("b2b_in_rdy", 32'(bus13.in_rdy), 32'd1);
      tick();
    end
    bus13.in_val = 1'b0;
    tick();
    tick();
    check_eq("b2b_count0", 32'(bus13.count0), 32'd1);
    check_eq("b2b_count1", 32'(bus13.count1), 32'd2);

    // Stall on out1 with 0x1ABC; a second message waits behind it.
    bus13.out0_rdy = 1'b0; bus13.out1_rdy = 1'b0;
    bus13.in_val = 1'b1; bus13.in_msg = 13'h1ABC; bus13.in_sel = 1'b1;
    tick();
    bus13.in_msg = 13'h0555; bus13.in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus13.out0_rdy = i[0];
      #1;
      check_eq("stall_out1_val", 32'(bus13.out1_val), 32'd1);
      check_eq("stall_out1_msg", 32'(bus13.out1_msg), 32'h1ABC);
      check_eq("stall_in_rdy",   32'(bus13.in_rdy),   32'd0);
      check_eq("stall_out0_val", 32'(bus13.out0_val), 32'd0);
      check_eq("stall_count0",   32'(bus13.count0),   32'd1);
      check_eq("stall_count1",   32'(bus13.count1),   32'd2);
      tick();
    end
    bus13.out1_rdy = 1'b1;
    #1;
    check_eq("release_in_rdy", 32'(bus13.in_rdy), 32'd1);
    tick();
    bus13.in_val = 1'b0; bus13.out0_rdy = 1'b1;
    #1;
    check_eq("release_out1_once", 32'(bus13.out1_val), 32'd0);
    check_eq("release_out0_val",  32'(bus13.out0_val), 32'd1);
    check_eq("release_out0_msg",  32'(bus13.out0_msg), 32'h0555);
    tick();
    tick();
    check_eq("release_count1", 32'(bus13.count1), 32'd3);
    check_eq("release_count0", 32'(bus13.count0), 32'd2);

    // Asynchronous reset mid-cycle with a stalled message in the buffer.
    bus13.out0_rdy = 1'b0; bus13.out1_rdy = 1'b0;
    bus13.in_val = 1'b1; bus13.in_msg = 13'h0777; bus13.in_sel = 1'b1;
    tick();
    bus13.in_val = 1'b0;
    #2;
    check_eq("pre_rst_out1_val", 32'(bus13.out1_val), 32'd1);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    m_cnt0 = 8'd0;
    m_cnt1 = 8'd0;
    #1;
    check_eq("async_rst_out1_val", 32'(bus13.out1_val), 32'd0);
    check_eq("async_rst_out1_msg", 32'(bus13.out1_msg), 32'd0);
    check_eq("async_rst_in_rdy",   32'(bus13.in_rdy),   32'd0);
    check_eq("async_rst_count0",   32'(bus13.count0),   32'd0);
    check_eq("async_rst_count1",   32'(bus13.count1),   32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    bus13.out0_rdy = 1'b1; bus13.out1_rdy = 1'b1;
    #1;
    check_eq("rerst_in_rdy", 32'(bus13.in_rdy), 32'd1);
    repeat (3) tick();
    check_eq("flushed_out1_val", 32'(bus13.out1_val), 32'd0);
    check_eq("flushed_count1",   32'(bus13.count1),   32'd0);

    // 256 messages to out0: count0 wraps back to zero.
    bus13.in_sel = 1'b0; bus13.in_val = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus13.in_msg = 13'(i);
      if (i == 128) begin
        #1;
        check_eq("wrap_mid_count0", 32'(bus13.count0), 32'd127);
      end
      tick();
    end
    bus13.in_val = 1'b0;
    tick();
    tick();
    check_eq("wrap_count0", 32'(bus13.count0), 32'd0);
    check_eq("wrap_count1", 32'(bus13.count1), 32'd0);
    check_eq("wrap_model0", 32'(bus13.count0), 32'(m_cnt0));

    // 20 random messages with random consumer readiness.
    sent = 0;
    bus13.in_msg = 13'($urandom);
    bus13.in_sel = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 1000 && sent < 20; cyc++) begin
      bus13.in_val   = 1'b1;
      bus13.out0_rdy = 1'($urandom_range(0, 1));
      bus13.out1_rdy = 1'($urandom_range(0, 1));
      #1;
      acc = bus13.in_rdy;
      tick();
      if (acc) begin
        sent++;
        bus13.in_msg = 13'($urandom);
        bus13.in_sel = 1'($urandom_range(0, 1));
      end
    end
    bus13.in_val = 1'b0;
    check_eq("rand_sent", 32'(sent), 32'd20);
    bus13.out0_rdy = 1'b1; bus13.out1_rdy = 1'b1;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    check_eq("rand_q0_empty", 32'(q0.size()), 32'd0);
    check_eq("rand_q1_empty", 32'(q1.size()), 32'd0);
    check_eq("rand_count0",   32'(bus13.count0), 32'(m_cnt0));
    check_eq("rand_count1",   32'(bus13.count1), 32'(m_cnt1));
    check_eq("rand_idle0",    32'(bus13.out0_val), 32'd0);
    check_eq("rand_idle1",    32'(bus13.out1_val), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
